// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Front-end fetch stage sitting directly in front of the instruction memory.
// It owns the program counter, presents it on pcOut, and captures the word
// the memory returns into an instruction register for the decode stage.
// It also handles stall, branch redirect with wrong-path squash, and a HALT
// opcode that parks the unit until resume is pulsed.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-low
//   stall        hold PC and instruction register this cycle
//   branchTaken  redirect request from the execute stage
//   branchTarget redirect target address
//   resume       leave the HALT state
//   IW           instruction word from memory (combinational on pcOut)
//   pcOut        fetch address to the instruction memory
//   irOut        captured instruction for decode
//   irPc         address of the instruction held in irOut
//   irValid      irOut holds a valid, non-squashed instruction
//   halted       unit is in the HALT state
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  IW_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000,
  parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branchTaken,
  input  logic [PC_WIDTH-1:0] branchTarget,
  input  logic                resume,
  input  logic [IW_WIDTH-1:0] IW,
  output logic [PC_WIDTH-1:0] pcOut,
  output logic [IW_WIDTH-1:0] irOut,
  output logic [PC_WIDTH-1:0] irPc,
  output logic                irValid,
  output logic                halted
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  state_t              stateQ;
  logic [PC_WIDTH-1:0] pcQ;
  logic [IW_WIDTH-1:0] irQ;
  logic [PC_WIDTH-1:0] irPcQ;
  logic                irValidQ;

  logic                isHaltOp;
  logic [PC_WIDTH-1:0] pcIncD;

  // The opcode field is the top six bits of the returned instruction word.
  assign isHaltOp = (IW[IW_WIDTH-1 -: 6] == HALT_OPCODE);

  // Unsigned increment; the top address wraps back to zero silently.
  assign pcIncD = pcQ + PC_WIDTH'(1);

  // Single state machine. A branch redirect outranks everything, including
  // stall and the HALT state, so a redirect is never lost. In HALT the stall
  // input is ignored; only a branch or resume moves the unit on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= FETCH;
      pcQ      <= RESET_PC;
      irQ      <= '0;
      irPcQ    <= '0;
      irValidQ <= 1'b0;
    end else if (branchTaken) begin
      // The word fetched this cycle is on the wrong path, so it is squashed.
      pcQ      <= branchTarget;
      irValidQ <= 1'b0;
      stateQ   <= FETCH;
    end else begin
      case (stateQ)
        FETCH: begin
          if (!stall) begin
            irQ      <= IW;
            irPcQ    <= pcQ;
            irValidQ <= 1'b1;
            // A halt instruction is issued once; the PC parks on its address.
            if (isHaltOp) begin
              stateQ <= HALT;
            end else begin
              pcQ <= pcIncD;
            end
          end
        end
        HALT: begin
          irValidQ <= 1'b0;
          if (resume) begin
            pcQ    <= pcIncD;
            stateQ <= FETCH;
          end
        end
        default: begin
          stateQ   <= FETCH;
          irValidQ <= 1'b0;
        end
      endcase
    end
  end

  assign pcOut   = pcQ;
  assign irOut   = irQ;
  assign irPc    = irPcQ;
  assign irValid = irValidQ;
  assign halted  = (stateQ == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit: a directed vector table walking
// through sequential fetch, stall, branch squash, halt/resume, the
// halt+branch tie and PC wrap; a hand-written asynchronous reset sequence;
// and a randomized run against a behavioural reference model that fetches
// from a small instruction memory.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic        resume;
  logic [31:0] iwBus;
  logic [15:0] pcOut;
  logic [31:0] irOut;
  logic [15:0] irPc;
  logic        irValid;
  logic        halted;

  logic [31:0] iwDrive;
  logic        useMem;
  logic [31:0] mem [256];

  int compared;
  int mismatched;

  typedef struct {
    logic        stall;
    logic        bt;
    logic [15:0] tgt;
    logic        resume;
    logic [31:0] iw;
    logic [15:0] ePc;
    logic [31:0] eIr;
    logic [15:0] eIrPc;
    logic        eValid;
    logic        eHalted;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [15:0] mPc;
  logic [31:0] mIr;
  logic [15:0] mIrPc;
  logic        mValid;
  logic        mHalted;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .resume       (resume),
    .IW           (iwBus),
    .pcOut        (pcOut),
    .irOut        (irOut),
    .irPc         (irPc),
    .irValid      (irValid),
    .halted       (halted)
  );

  // Instruction memory is combinational on the fetch address.
  assign iwBus = useMem ? mem[pcOut[7:0]] : iwDrive;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                              input logic r, input logic [31:0] w,
                              input logic [15:0] p, input logic [31:0] ir,
                              input logic [15:0] ip, input logic v, input logic h);
    vec_t x;
    x.stall = s; x.bt = b; x.tgt = t; x.resume = r; x.iw = w;
    x.ePc = p; x.eIr = ir; x.eIrPc = ip; x.eValid = v; x.eHalted = h;
    return x;
  endfunction

  task automatic applyStimulus(input logic s, input logic b, input logic [15:0] t,
                               input logic r, input logic [31:0] w);
    stall        = s;
    branchTaken  = b;
    branchTarget = t;
    resume       = r;
    iwDrive      = w;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] p,
                             input logic [31:0] ir, input logic [15:0] ip,
                             input logic v, input logic h);
    compared++;
    if (pcOut !== p || irOut !== ir || irPc !== ip || irValid !== v || halted !== h) begin
      mismatched++;
      $display("[TB] FAIL %s: got pc=%h ir=%h irPc=%h v=%b h=%b, want pc=%h ir=%h irPc=%h v=%b h=%b",
               name, pcOut, irOut, irPc, irValid, halted, p, ir, ip, v, h);
    end
  endtask

  // Reference step: compute the next architectural state from the current
  // one and this cycle's inputs, using the instruction memory contents.
  task automatic modelStep(input logic s, input logic b, input logic [15:0] t,
                           input logic r);
    logic [31:0] w;
    w = mem[mPc[7:0]];
    if (b) begin
      mPc = t; mValid = 1'b0; mHalted = 1'b0;
    end else if (mHalted) begin
      mValid = 1'b0;
      if (r) begin
        mPc = mPc + 16'd1; mHalted = 1'b0;
      end
    end else if (!s) begin
      mIr = w; mIrPc = mPc; mValid = 1'b1;
      if (w[31:26] == 6'h3F) mHalted = 1'b1;
      else mPc = mPc + 16'd1;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    useMem     = 1'b0;
    rst_n      = 1'b0;
    applyStimulus(0, 0, 16'h0, 0, 32'h80280032);

    // Directed table: inputs applied for one edge, outputs expected after it.
    vecs.push_back(mk(0,0,16'h0000,0,32'h80280032, 16'h0001,32'h80280032,16'h0000,1,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h85700000, 16'h0002,32'h85700000,16'h0001,1,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h00000002, 16'h0003,32'h00000002,16'h0002,1,0));
    vecs.push_back(mk(1,0,16'h0000,0,32'h00000003, 16'h0003,32'h00000002,16'h0002,1,0));
    vecs.push_back(mk(1,0,16'h0000,0,32'h00000003, 16'h0003,32'h00000002,16'h0002,1,0));
    vecs.push_back(mk(1,0,16'h0000,0,32'h00000003, 16'h0003,32'h00000002,16'h0002,1,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h00000003, 16'h0004,32'h00000003,16'h0003,1,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h00000004, 16'h0005,32'h00000004,16'h0004,1,0));
    vecs.push_back(mk(1,1,16'd26,  0,32'h00000005, 16'd26, 32'h00000004,16'h0004,0,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h0000001A, 16'd27, 32'h0000001A,16'd26,  1,0));
    vecs.push_back(mk(0,1,16'd7,   0,32'h0000001B, 16'd7,  32'h0000001A,16'd26,  0,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'hFC000000, 16'd7,  32'hFC000000,16'd7,   1,1));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(k == 4,0,16'h0000,0,32'hFC000000, 16'd7,32'hFC000000,16'd7,0,1));
    vecs.push_back(mk(0,0,16'h0000,1,32'hFC000000, 16'd8,  32'hFC000000,16'd7,   0,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h00000008, 16'd9,  32'h00000008,16'd8,   1,0));
    vecs.push_back(mk(0,1,16'd12,  0,32'h00000009, 16'd12, 32'h00000008,16'd8,   0,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'hFC000000, 16'd12, 32'hFC000000,16'd12,  1,1));
    vecs.push_back(mk(0,1,16'd40,  1,32'hFC000000, 16'd40, 32'hFC000000,16'd12,  0,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h00000028, 16'd41, 32'h00000028,16'd40,  1,0));
    vecs.push_back(mk(0,1,16'hFFFF,0,32'h00000029, 16'hFFFF,32'h00000028,16'd40, 0,0));
    vecs.push_back(mk(0,0,16'h0000,0,32'h000000AB, 16'h0000,32'h000000AB,16'hFFFF,1,0));

    // Reset state with rst_n held low
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_hold", 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stall, vecs[i].bt, vecs[i].tgt, vecs[i].resume, vecs[i].iw);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eIr, vecs[i].eIrPc,
                  vecs[i].eValid, vecs[i].eHalted);
    end

    // Asynchronous reset mid-cycle, with a branch pending that must be dropped.
    applyStimulus(0, 0, 16'h0, 0, 32'h00000055);
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    branchTaken  = 1'b1;
    branchTarget = 16'd99;
    #1;
    checkOutput("async_reset_immediate", 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_drops_branch", 16'h0000, 32'h0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 16'h0, 0, 32'h00000011);
    @(posedge clk);
    @(negedge clk);
    checkOutput("first_fetch_after_reset", 16'h0001, 32'h00000011, 16'h0000, 1'b1, 1'b0);

    // Randomized run against the reference model
    for (int a = 0; a < 256; a++) begin
      mem[a] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[a][31:26] = 6'h3F;
      else if (mem[a][31:26] == 6'h3F) mem[a][31:26] = 6'h00;
    end
    useMem = 1'b1;
    rst_n  = 1'b0;
    applyStimulus(0, 0, 16'h0, 0, 32'h0);
    #1;
    mPc = 16'h0000; mIr = 32'h0; mIrPc = 16'h0000; mValid = 1'b0; mHalted = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic s, b, r;
      logic [15:0] t;
      b = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) == 0);
      s = r ? 1'b0 : ($urandom_range(0, 4) == 0);
      t = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 3)))
                                     : 16'($urandom_range(0, 65535));
      applyStimulus(s, b, t, r, 32'h0);
      modelStep(s, b, t, r);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rand%0d", c), mPc, mIr, mIrPc, mValid, mHalted);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
